dual_wave_sample_gen: RTL and testbench

- Dual-channel waveform sample source; sits directly upstream of the dual-channel SPI DAC serializer and drives its channel A/B 12-bit data inputs.
- Per channel: DDS phase accumulator plus waveform shaper (DC, sawtooth, triangle, square, sine).
- An internal divider paces the sample rate to the serializer frame rate.

---
 rtl/wave_gen_pkg.sv | 45 ++++
 rtl/sine_quarter_lut.sv | 37 +++
 rtl/dual_wave_sample_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_dual_wave_sample_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wave_gen_pkg.sv
`default_nettype none
// ============================================================================
// wave_gen_pkg: shared types, constants and the sine-table builder.
// Rev 1.0
// ============================================================================
package wave_gen_pkg;

    typedef enum logic [2:0] {
        WAVE_DC  = 3'd0,
        WAVE_SAW = 3'd1,
        WAVE_TRI = 3'd2,
        WAVE_SQR = 3'd3,
        WAVE_SIN = 3'd4
    } wave_e;

    localparam int                 SAMPLE_W = 12;
    localparam logic [SAMPLE_W-1:0] MIDSCALE = 12'h800;
    localparam int                 LUT_AW   = 8;

    // pi in Q40 fixed point
    localparam logic [47:0] c_pi_q40 = 48'h3243F6A8886;

    // round(2047*sin((i+0.5)*pi/512)) by Q40 Taylor series; elaboration-time only
    function automatic logic [10:0] sine_mag(input int unsigned i);
        logic [127:0] x, x2, term, acc, y;
        x    = (128'(2 * i + 1) * 128'(c_pi_q40)) >> 10;
        x2   = (x * x) >> 40;
        term = x;
        acc  = x;
        for (int k = 1; k <= 9; k++) begin
            term = ((term * x2) >> 40) / 128'((2 * k) * (2 * k + 1));
            if (k % 2 == 1) acc = acc - term;
            else            acc = acc + term;
        end
        y = (acc * 128'd2047 + (128'd1 << 39)) >> 40;
        return 11'(y);
    endfunction

    // Step through the legal waveform codes, skipping the reserved ones
    function automatic logic [2:0] next_wave(input logic [2:0] s);
        return (s >= 3'd4) ? 3'd0 : s + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sine_quarter_lut.sv
`default_nettype none
// ============================================================================
// sine_quarter_lut: registered 256x11 quarter-wave sine magnitude ROM.
// Rev 1.0
// ============================================================================
module sine_quarter_lut
    import wave_gen_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [LUT_AW-1:0] idx,
    output logic [10:0]       mag
);

    logic [10:0] rom_w [2**LUT_AW];
    logic [10:0] mag_d, mag_q;

    for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
        localparam logic [10:0] c_val = sine_mag(i);
        assign rom_w[i] = c_val;
    end

    always_comb begin
        mag_d = mag_q;
        if (en) mag_d = rom_w[idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mag_q <= '0;
        else        mag_q <= mag_d;
    end

    assign mag = mag_q;

endmodule
`default_nettype wire

// File: rtl/dual_wave_sample_gen.sv
`default_nettype none
// ============================================================================
// dual_wave_sample_gen: two-channel DDS sample source feeding the SPI DAC.
// Optional macro WAVE_PB_CYCLE_EN: debounced pushbuttons cycle each waveform.
// Rev 1.0
// ============================================================================
module dual_wave_sample_gen
    import wave_gen_pkg::*;
#(
    parameter int ACC_W      = 24,
    parameter int TICK_DIV   = 2000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             phase_rst,
    input  logic [2:0]       wave_sel_a,
    input  logic [2:0]       wave_sel_b,
    input  logic [ACC_W-1:0] freq_word_a,
    input  logic [ACC_W-1:0] freq_word_b,
    input  logic [11:0]      dc_level_a,
    input  logic [11:0]      dc_level_b,
    input  logic             pb_a,
    input  logic             pb_b,
    output logic [11:0]      ch_a_data,
    output logic [11:0]      ch_b_data,
    output logic             sample_valid
);

    localparam int c_div_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_term = c_div_w'(TICK_DIV - 1);

    logic [c_div_w-1:0] div_d, div_q;
    logic tick_d, tick_q, v1_d, v1_q, v2_d, v2_q, valid_d, valid_q;

    // When disabled every stage holds, so an in-flight sample resumes later
    always_comb begin
        div_d   = div_q;
        tick_d  = tick_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        valid_d = 1'b0;
        if (enable) begin
            tick_d  = (div_q == c_div_term);
            div_d   = tick_d ? '0 : div_q + c_div_w'(1);
            v1_d    = tick_q;
            v2_d    = v1_q;
            valid_d = v2_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            tick_q  <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            tick_q  <= tick_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            valid_q <= valid_d;
        end
    end

    logic w_s1, w_s2, w_s3;
    assign w_s1 = enable & tick_q;
    assign w_s2 = enable & v1_q;
    assign w_s3 = enable & v2_q;

    logic [2:0]       sel_in_w [2];
    logic [ACC_W-1:0] fw_w     [2];
    logic [11:0]      dc_w     [2];
    logic             pb_w     [2];
    logic [11:0]      data_w   [2];

    assign sel_in_w[0] = wave_sel_a;
    assign sel_in_w[1] = wave_sel_b;
    assign fw_w[0]     = freq_word_a;
    assign fw_w[1]     = freq_word_b;
    assign dc_w[0]     = dc_level_a;
    assign dc_w[1]     = dc_level_b;
    assign pb_w[0]     = pb_a;
    assign pb_w[1]     = pb_b;

`ifndef WAVE_PB_CYCLE_EN
    localparam int c_unused_deb = DEB_CYCLES;
`endif

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [2:0]          sel_w;
        logic [ACC_W-1:0]    phase_d, phase_q;
        logic [2:0]          sel1_d, sel1_q, sel2_d, sel2_q;
        logic [11:0]         dc1_d, dc1_q, dc2_d, dc2_q;
        logic [SAMPLE_W-1:0] p_w, p2_d, p2_q;
        logic [11:0]         data_d, data_q;
        logic [LUT_AW-1:0]   idx_w;
        logic [10:0]         mag_w;

`ifdef WAVE_PB_CYCLE_EN
        localparam int c_deb_w = $clog2(DEB_CYCLES + 1);
        logic                sync1_q, sync2_q, stable_d, stable_q;
        logic [c_deb_w-1:0]  deb_d, deb_q;
        logic [2:0]          sel_int_d, sel_int_q;
        logic                unused_sel;

        // Input must differ from the stable level for DEB_CYCLES straight clks
        always_comb begin
            stable_d  = stable_q;
            deb_d     = '0;
            sel_int_d = sel_int_q;
            if (sync2_q != stable_q) begin
                if (deb_q == c_deb_w'(DEB_CYCLES - 1)) begin
                    stable_d = sync2_q;
                    if (sync2_q) sel_int_d = next_wave(sel_int_q);
                end else begin
                    deb_d = deb_q + c_deb_w'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                stable_q  <= 1'b0;
                deb_q     <= '0;
                sel_int_q <= 3'd0;
            end else begin
                sync1_q   <= pb_w[c];
                sync2_q   <= sync1_q;
                stable_q  <= stable_d;
                deb_q     <= deb_d;
                sel_int_q <= sel_int_d;
            end
        end

        assign sel_w      = sel_int_q;
        assign unused_sel = ^sel_in_w[c];
`else
        logic unused_pb;
        assign sel_w     = sel_in_w[c];
        assign unused_pb = pb_w[c];
`endif

        assign p_w   = phase_q[ACC_W-1 -: SAMPLE_W];
        assign idx_w = p_w[10] ? ~p_w[9:2] : p_w[9:2];

        sine_quarter_lut u_lut (
            .clk   (clk),
            .reset (reset),
            .en    (w_s2),
            .idx   (idx_w),
            .mag   (mag_w)
        );

        always_comb begin
            phase_d = phase_q;
            sel1_d  = sel1_q;
            dc1_d   = dc1_q;
            p2_d    = p2_q;
            sel2_d  = sel2_q;
            dc2_d   = dc2_q;
            data_d  = data_q;
            if (w_s1) begin
                phase_d = phase_q + fw_w[c];
                sel1_d  = sel_w;
                dc1_d   = dc_w[c];
            end
            // Clear wins over a coincident increment
            if (phase_rst) phase_d = '0;
            if (w_s2) begin
                p2_d   = p_w;
                sel2_d = sel1_q;
                dc2_d  = dc1_q;
            end
            if (w_s3) begin
                case (sel2_q)
                    WAVE_DC:  data_d = dc2_q;
                    WAVE_SAW: data_d = p2_q;
                    WAVE_TRI: data_d = p2_q[11] ? ~{p2_q[10:0], 1'b0} : {p2_q[10:0], 1'b0};
                    WAVE_SQR: data_d = p2_q[11] ? 12'd0 : 12'd4095;
                    WAVE_SIN: data_d = p2_q[11] ? 12'd2047 - {1'b0, mag_w}
                                                : 12'd2048 + {1'b0, mag_w};
                    default:  data_d = MIDSCALE;
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                phase_q <= '0;
                sel1_q  <= 3'd0;
                dc1_q   <= '0;
                p2_q    <= '0;
                sel2_q  <= 3'd0;
                dc2_q   <= '0;
                data_q  <= MIDSCALE;
            end else begin
                phase_q <= phase_d;
                sel1_q  <= sel1_d;
                dc1_q   <= dc1_d;
                p2_q    <= p2_d;
                sel2_q  <= sel2_d;
                dc2_q   <= dc2_d;
                data_q  <= data_d;
            end
        end

        assign data_w[c] = data_q;
    end

    assign ch_a_data    = data_w[0];
    assign ch_b_data    = data_w[1];
    assign sample_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_dual_wave_sample_gen.sv
`default_nettype none
// ============================================================================
// tb_dual_wave_sample_gen: randomized bench with a behavioural sample model.
// Rev 1.0
// ============================================================================
module tb_dual_wave_sample_gen;

    localparam int TICK = 20;
    localparam int ACC  = 24;
    localparam int DEB  = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            enable = 1'b0;
    logic            phase_rst = 1'b0;
    logic [2:0]      wave_sel_a = 3'd0, wave_sel_b = 3'd0;
    logic [ACC-1:0]  freq_word_a = '0, freq_word_b = '0;
    logic [11:0]     dc_level_a = 12'h123, dc_level_b = 12'h456;
    logic            pb_a = 1'b0, pb_b = 1'b0;
    logic [11:0]     ch_a_data, ch_b_data;
    logic            sample_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ACC-1:0] phase_m [2];
    int             exp_m   [2];
    int             pb_sel_m [2];

    dual_wave_sample_gen #(
        .ACC_W      (ACC),
        .TICK_DIV   (TICK),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .phase_rst    (phase_rst),
        .wave_sel_a   (wave_sel_a),
        .wave_sel_b   (wave_sel_b),
        .freq_word_a  (freq_word_a),
        .freq_word_b  (freq_word_b),
        .dc_level_a   (dc_level_a),
        .dc_level_b   (dc_level_b),
        .pb_a         (pb_a),
        .pb_b         (pb_b),
        .ch_a_data    (ch_a_data),
        .ch_b_data    (ch_b_data),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Sine from quadrant symmetry of a half-sample-offset quarter table
    function automatic int sine_out(input int p);
        int  k, i, mag;
        real v;
        k   = (p % 2048) / 4;
        i   = (k < 256) ? k : 511 - k;
        v   = 2047.0 * $sin((real'(i) + 0.5) * 3.141592653589793 / 512.0);
        mag = $rtoi(v + 0.5);
        return (p < 2048) ? 2048 + mag : 2047 - mag;
    endfunction

    function automatic int shape(input int p, input int sel, input int dc);
        case (sel)
            0:       return dc;
            1:       return p;
            2:       return (p < 2048) ? 2 * p : 4095 - 2 * (p - 2048);
            3:       return (p < 2048) ? 4095 : 0;
            4:       return sine_out(p);
            default: return 2048;
        endcase
    endfunction

    // Wait for the next sample_valid, advance the model and compare both channels
    task automatic take_sample(input bit rst_launch, input bit do_check, input int exp_gap);
        int  n = 0;
        bit  seen = 1'b0;
        int  sel, dc;
        logic [ACC-1:0] fw;
        while (!seen && n < 3 * TICK + 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (sample_valid) seen = 1'b1;
        end
        if (!seen) begin
            check_val("sample_timeout", 32'd0, 32'd1);
            return;
        end
        if (exp_gap > 0) check_val("valid_gap", n, exp_gap);
        for (int c = 0; c < 2; c++) begin
            fw = (c == 0) ? freq_word_a : freq_word_b;
            dc = (c == 0) ? int'(dc_level_a) : int'(dc_level_b);
`ifdef WAVE_PB_CYCLE_EN
            sel = pb_sel_m[c];
`else
            sel = (c == 0) ? int'(wave_sel_a) : int'(wave_sel_b);
`endif
            phase_m[c] = rst_launch ? '0 : phase_m[c] + fw;
            exp_m[c]   = shape(int'(phase_m[c][ACC-1 -: 12]), sel, dc);
        end
        if (do_check) begin
            check_val("ch_a", ch_a_data, exp_m[0]);
            check_val("ch_b", ch_b_data, exp_m[1]);
        end
    endtask

    task automatic mid_rst_sample();
        phase_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        phase_rst = 1'b0;
        phase_m[0] = '0;
        phase_m[1] = '0;
        take_sample(1'b0, 1'b1, TICK - 1);
    endtask

    // Called just after a sample_valid: the next launch edge is TICK-2 clks away
    task automatic coincident_rst_sample();
        repeat (TICK - 3) @(posedge clk);
        @(negedge clk);
        phase_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        phase_rst = 1'b0;
        take_sample(1'b1, 1'b1, 2);
    endtask

    initial begin
        int held_bad, valid_seen, mode;
        phase_m[0] = '0; phase_m[1] = '0;
        pb_sel_m[0] = 0; pb_sel_m[1] = 0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_ch_a", ch_a_data, 12'h800);
        check_val("rst_ch_b", ch_b_data, 12'h800);
        check_val("rst_valid", sample_valid, 0);

`ifndef WAVE_PB_CYCLE_EN
        wave_sel_a = 3'd1; freq_word_a = 24'd4096;
        wave_sel_b = 3'd3; freq_word_b = 24'h400000;
        reset = 1'b1;
        take_sample(1'b0, 1'b1, TICK + 3);
        repeat (3) take_sample(1'b0, 1'b1, TICK);

        wave_sel_b = 3'd2;
        mid_rst_sample();
        repeat (3) take_sample(1'b0, 1'b1, TICK);

        wave_sel_a = 3'd4; freq_word_a = 24'h400000;
        repeat (4) take_sample(1'b0, 1'b1, TICK);
        coincident_rst_sample();
        check_val("sine_p0", ch_a_data, 2054);

        for (int r = 0; r < 16; r++) begin
            wave_sel_a  = 3'($urandom_range(0, 7));
            wave_sel_b  = 3'($urandom_range(0, 7));
            freq_word_a = 24'($urandom());
            freq_word_b = 24'($urandom());
            dc_level_a  = 12'($urandom());
            dc_level_b  = 12'($urandom());
            mode        = $urandom_range(0, 3);
            if (mode == 1)      mid_rst_sample();
            else if (mode == 2) coincident_rst_sample();
            else                take_sample(1'b0, 1'b1, TICK);
        end

        enable = 1'b0;
        held_bad = 0;
        valid_seen = 0;
        repeat (5000) begin
            @(posedge clk);
            @(negedge clk);
            if (sample_valid) valid_seen++;
            if (ch_a_data != exp_m[0] || ch_b_data != exp_m[1]) held_bad++;
        end
        check_val("disabled_valid", valid_seen, 0);
        check_val("disabled_hold", held_bad, 0);
        enable = 1'b1;
        take_sample(1'b0, 1'b1, TICK);

        reset = 1'b0;
        #1;
        check_val("async_rst_valid", sample_valid, 0);
        check_val("async_rst_ch_a", ch_a_data, 12'h800);
        check_val("async_rst_ch_b", ch_b_data, 12'h800);
        repeat (3) @(negedge clk);
        phase_m[0] = '0; phase_m[1] = '0;
        wave_sel_a = 3'd1; freq_word_a = 24'd4096;
        reset = 1'b1;
        take_sample(1'b0, 1'b1, TICK + 3);
        take_sample(1'b0, 1'b1, TICK);
`else
        freq_word_a = '0; freq_word_b = '0;
        wave_sel_a = 3'd3; wave_sel_b = 3'd1;
        reset = 1'b1;
        take_sample(1'b0, 1'b1, TICK + 3);
        pb_a = 1'b1;
        repeat (3) @(negedge clk);
        pb_a = 1'b0;
        take_sample(1'b0, 1'b0, 0);
        take_sample(1'b0, 1'b1, 0);
        for (int k = 0; k < 5; k++) begin
            pb_a = 1'b1;
            repeat (DEB + 6) @(negedge clk);
            pb_a = 1'b0;
            repeat (DEB + 6) @(negedge clk);
            pb_sel_m[0] = (pb_sel_m[0] + 1) % 5;
            take_sample(1'b0, 1'b0, 0);
            take_sample(1'b0, 1'b1, 0);
        end
        check_val("pb_back_to_dc", ch_a_data, dc_level_a);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
